instr_loader: RTL and testbench

Host-side load and readback engine for the 32-bit RISC core's instruction memory. It accepts the instruction words a host or bench presents on the 32-bit data input under a `start` strobe and writes them sequentially into imem. It then releases the core by asserting `cpu_run`, and serves single-word readback requests (`rd_req` with `rd_addr`). It sits between the top-level host data pins and the imem write/read port.

---
 rtl/instr_loader.sv | 95 +++++++++
 tb/tb_instr_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: host-side sequential imem loader with single-word readback and core release
module instr_loader #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          cpu_run,
    output logic [AW:0]   word_count,
    output logic          overflow,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, RD_ISSUE, RD_WAIT} state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state, state_nx, ret_state;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] data_q;
    logic          full, accept;

    assign full       = count == DEPTH;
    assign accept     = (state == IDLE || state == LOAD) && start;
    assign rd_valid   = state == RD_WAIT;
    assign data_out   = rd_valid ? mem_rdata : data_q;
    assign busy       = state == LOAD || state == RD_ISSUE || state == RD_WAIT;
    assign word_count = count;

    // next state and imem port drive; reset forces the port quiet immediately
    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE:     state_nx = start ? LOAD : rd_req ? RD_ISSUE : IDLE;
            LOAD:     state_nx = start ? LOAD : RUN;
            RUN:      state_nx = rd_req ? RD_ISSUE : RUN;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  state_nx = ret_state;
            default:  state_nx = IDLE;
        endcase
        if (accept && !full) begin
            mem_we    = 1'b1;
            mem_addr  = count[AW-1:0];
            mem_wdata = data_in;
        end
        if (state == RD_ISSUE) begin
            mem_re   = 1'b1;
            mem_addr = rd_addr_q;
        end
        if (reset) begin
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // state, write pointer, sticky flags and readback capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ret_state <= IDLE;
            count     <= '0;
            rd_addr_q <= '0;
            data_q    <= '0;
            overflow  <= 1'b0;
            cpu_run   <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= mem_we ? count + (AW+1)'(1) : count;
            overflow <= overflow | (accept && full);
            cpu_run  <= cpu_run | (state == LOAD && !start);
            if (state_nx == RD_ISSUE) begin
                rd_addr_q <= rd_addr;
                ret_state <= state;
            end
            if (state == RD_WAIT) data_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader with a synchronous-read imem model
module tb_instr_loader;
    logic        clk = 1'b0;
    logic        reset, start, rd_req;
    logic [31:0] data_in;
    logic [2:0]  rd_addr;
    logic        mem_we, mem_re, rd_valid, cpu_run, overflow, busy;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, data_out;
    logic [3:0]  word_count;

    logic [31:0] mem [8];
    logic [34:0] wq [$];
    logic [2:0]  rq [$];
    logic [31:0] dq [$];
    int total = 0;
    int bad = 0;

    instr_loader dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .rd_req(rd_req), .rd_addr(rd_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .data_out(data_out), .rd_valid(rd_valid), .cpu_run(cpu_run),
        .word_count(word_count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // imem model: write on we, registered read one cycle after re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got event with value %h expected no event", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: pop expected write/read events as the DUT presents them
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (wq.size() == 0) unexpected("write", {29'd0, mem_addr});
                else begin
                    logic [34:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[34:32]));
                    chk("wr_data", mem_wdata, e[31:0]);
                end
            end
            if (mem_re) begin
                if (rq.size() == 0) unexpected("mem_re", {29'd0, mem_addr});
                else chk("re_addr", 32'(mem_addr), 32'(rq.pop_front()));
            end
            if (rd_valid) begin
                if (dq.size() == 0) unexpected("rd_valid", data_out);
                else chk("rd_data", data_out, dq.pop_front());
            end
            if (mem_we && mem_re) unexpected("we_re_both", 32'(mem_addr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem_rdata = '0;
        reset = 1'b1; start = 1'b0; rd_req = 1'b0; data_in = '0; rd_addr = '0;
        repeat (3) step();
        reset = 1'b0;
        // test 1: reset during LOAD
        start = 1'b1; data_in = 32'hDEADBEEF; wq.push_back({3'd0, 32'hDEADBEEF}); step();
        data_in = 32'hCAFEF00D; wq.push_back({3'd1, 32'hCAFEF00D}); step();
        reset = 1'b1; data_in = 32'h55555555;
        repeat (5) step();
        reset = 1'b0; start = 1'b0;
        chk("rst_cpu_run", 32'(cpu_run), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", 32'(busy), 0);
        // test 2: single load
        start = 1'b1; data_in = 32'h480C0123; wq.push_back({3'd0, 32'h480C0123}); step();
        start = 1'b0;
        chk("single_count", 32'(word_count), 1);
        chk("single_run_early", 32'(cpu_run), 0);
        step();
        chk("single_run", 32'(cpu_run), 1);
        reset = 1'b1; step(); reset = 1'b0;
        // test 3: burst load
        start = 1'b1;
        data_in = 32'h480C0123; wq.push_back({3'd0, 32'h480C0123}); step();
        data_in = 32'h00000000; wq.push_back({3'd1, 32'h00000000}); step();
        data_in = 32'h00000013; wq.push_back({3'd2, 32'h00000013}); step();
        start = 1'b0;
        chk("burst_count", 32'(word_count), 3);
        chk("burst_run_early", 32'(cpu_run), 0);
        step();
        chk("burst_run", 32'(cpu_run), 1);
        // test 5: readback in RUN, with a second request while busy
        rd_req = 1'b1; rd_addr = 3'd1; rq.push_back(3'd1); dq.push_back(32'h0); step();
        rd_addr = 3'd2;
        chk("rd_issue_run", 32'(cpu_run), 1);
        chk("rd_issue_busy", 32'(busy), 1);
        step();
        rd_req = 1'b0;
        chk("rd_wait_run", 32'(cpu_run), 1);
        step();
        chk("rd_ret_busy", 32'(busy), 0);
        rd_req = 1'b1; rd_addr = 3'd0; rq.push_back(3'd0); dq.push_back(32'h480C0123); step();
        rd_req = 1'b0; step(); step(); step();
        chk("rd_hold", data_out, 32'h480C0123);
        chk("rd_hold_valid", 32'(rd_valid), 0);
        start = 1'b1; data_in = 32'hFFFFFFFF; step();
        start = 1'b0;
        chk("run_start_ignored", 32'(word_count), 3);
        chk("run_still", 32'(cpu_run), 1);
        // test 4: overflow
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 32'h100 + 32'(i);
            if (i < 8) wq.push_back({3'(i), 32'h100 + 32'(i)});
            step();
            if (i == 7) chk("ovf_not_yet", 32'(overflow), 0);
        end
        start = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(word_count), 8);
        chk("ovf_busy", 32'(busy), 1);
        step();
        chk("ovf_run", 32'(cpu_run), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        // test 6: readback from IDLE, then start/rd_req collisions
        reset = 1'b1; step(); reset = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd7; rq.push_back(3'd7); dq.push_back(32'h107); step();
        rd_req = 1'b0; step(); step();
        chk("idle_rd_run", 32'(cpu_run), 0);
        chk("idle_rd_busy", 32'(busy), 0);
        chk("idle_rd_hold", data_out, 32'h107);
        start = 1'b1; rd_req = 1'b1; rd_addr = 3'd5;
        data_in = 32'h11111111; wq.push_back({3'd0, 32'h11111111}); step();
        rd_addr = 3'd3;
        data_in = 32'h22222222; wq.push_back({3'd1, 32'h22222222}); step();
        start = 1'b0; rd_req = 1'b0;
        chk("coll_count", 32'(word_count), 2);
        step();
        chk("coll_run", 32'(cpu_run), 1);
        step(); step();
        chk("wq_empty", 32'(wq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
